// File: rtl/morse_rx.sv
// rtl/morse_rx.sv - Morse keying-line receiver with ASCII output FIFO
//
// Samples an on/off keying line and times its runs in units of PRESCALER
// clocks. Each run is classified as a dot, a dash or a glitch, and each
// completed character is decoded to ASCII and pushed into a
// first-word-fall-through FIFO that the host drains.
//
// Optional feature: define MORSE_RX_OVERFLOW_EN to build the sticky overflow
// flag. When it is undefined, overflow is tied low. Characters that arrive
// while the FIFO is full are dropped in both builds.
//
// Parameters:
//   PRESCALER  clock cycles per Morse time unit (>= 4)
//   DEPTH      output FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk        system clock
//   arst_n     asynchronous active-low reset
//   morse_in   keying line, 1 = key down; asynchronous to clk
//   read_en    pops the head character when the FIFO is not empty
//   ascii_out  FIFO head character; 0x00 when the FIFO is empty
//   empty      FIFO empty
//   overflow   sticky flag: a character was dropped because the FIFO was full

module morse_rx #(
    parameter int PRESCALER = 5000000,
    parameter int DEPTH     = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       morse_in,
    input  logic       read_en,
    output logic [7:0] ascii_out,
    output logic       empty,
    output logic       overflow
);

    localparam int CW = $clog2(7 * PRESCALER + 1);
    localparam int AW = $clog2(DEPTH);

    localparam logic [CW-1:0] T_HALF = CW'(PRESCALER / 2);
    localparam logic [CW-1:0] T_TWO  = CW'(2 * PRESCALER);
    localparam logic [CW-1:0] T_FIVE = CW'(5 * PRESCALER);
    localparam logic [CW-1:0] T_SAT  = CW'(7 * PRESCALER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------
    logic sync1, sync2, line_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            line_q <= 1'b0;
        end else begin
            sync1  <= morse_in;
            sync2  <= sync1;
            line_q <= sync2;
        end
    end

    logic rise, fall, level_change;
    assign rise         = sync2 & ~line_q;
    assign fall         = ~sync2 & line_q;
    assign level_change = sync2 ^ line_q;

    // ------------------------------------------------------------------
    // Run counter. On a level-change cycle it holds the length of the run
    // that just ended. On any other cycle it holds the length of the
    // current run so far.
    // ------------------------------------------------------------------
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            run_cnt <= '0;
        end else if (level_change) begin
            run_cnt <= CW'(1);
        end else if (run_cnt != T_SAT) begin
            run_cnt <= run_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Symbol accumulation state
    // ------------------------------------------------------------------
    logic [5:0] sym;        // bit i = i-th received symbol, 1 = dash
    logic [2:0] sym_cnt;
    logic       sym_err;    // a 7th symbol was received
    logic       word_pending;

    logic       sym_pending;
    assign sym_pending = (sym_cnt != 3'd0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    state_t state, state_next;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MARK;
                end
            end
            MARK: begin
                if (fall) begin
                    if (run_cnt < T_HALF && !sym_pending) begin
                        state_next = IDLE;
                    end else begin
                        state_next = SPACE;
                    end
                end
            end
            SPACE: begin
                // If the key goes down again on the same cycle that the gap
                // completes the character, decode and go straight to MARK so
                // that the new mark is not lost.
                if (run_cnt == T_TWO) begin
                    state_next = rise ? MARK : IDLE;
                end else if (rise) begin
                    state_next = MARK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    logic shift_en, shift_bit, decode_en, space_en;

    always_comb begin
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        decode_en = 1'b0;
        space_en  = 1'b0;
        case (state)
            IDLE: begin
                space_en = word_pending && (run_cnt == T_FIVE);
            end
            MARK: begin
                shift_en  = fall && (run_cnt >= T_HALF);
                shift_bit = (run_cnt >= T_TWO);
            end
            SPACE: begin
                decode_en = (run_cnt == T_TWO);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Symbol register, count, error bit and word_pending
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sym          <= '0;
            sym_cnt      <= '0;
            sym_err      <= 1'b0;
            word_pending <= 1'b0;
        end else begin
            if (decode_en) begin
                sym     <= '0;
                sym_cnt <= '0;
                sym_err <= 1'b0;
            end else if (shift_en) begin
                if (sym_cnt == 3'd6) begin
                    sym_err <= 1'b1;
                end else begin
                    sym[sym_cnt] <= shift_bit;
                    sym_cnt      <= sym_cnt + 3'd1;
                end
            end

            if (decode_en) begin
                word_pending <= 1'b1;
            end else if (space_en) begin
                word_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decoder. The key is {count, symbols}, with the first symbol in bit 0.
    // Symbol bits above the count are always zero.
    // ------------------------------------------------------------------
    logic [7:0] decoded;

    always_comb begin
        decoded = 8'h3F;
        if (!sym_err) begin
            case ({sym_cnt, sym})
                {3'd1, 6'd0}:  decoded = 8'h45; // E
                {3'd1, 6'd1}:  decoded = 8'h54; // T
                {3'd2, 6'd0}:  decoded = 8'h49; // I
                {3'd2, 6'd1}:  decoded = 8'h4E; // N
                {3'd2, 6'd2}:  decoded = 8'h41; // A
                {3'd2, 6'd3}:  decoded = 8'h4D; // M
                {3'd3, 6'd0}:  decoded = 8'h53; // S
                {3'd3, 6'd1}:  decoded = 8'h44; // D
                {3'd3, 6'd2}:  decoded = 8'h52; // R
                {3'd3, 6'd3}:  decoded = 8'h47; // G
                {3'd3, 6'd4}:  decoded = 8'h55; // U
                {3'd3, 6'd5}:  decoded = 8'h4B; // K
                {3'd3, 6'd6}:  decoded = 8'h57; // W
                {3'd3, 6'd7}:  decoded = 8'h4F; // O
                {3'd4, 6'd0}:  decoded = 8'h48; // H
                {3'd4, 6'd1}:  decoded = 8'h42; // B
                {3'd4, 6'd2}:  decoded = 8'h4C; // L
                {3'd4, 6'd3}:  decoded = 8'h5A; // Z
                {3'd4, 6'd4}:  decoded = 8'h46; // F
                {3'd4, 6'd5}:  decoded = 8'h43; // C
                {3'd4, 6'd6}:  decoded = 8'h50; // P
                {3'd4, 6'd8}:  decoded = 8'h56; // V
                {3'd4, 6'd9}:  decoded = 8'h58; // X
                {3'd4, 6'd11}: decoded = 8'h51; // Q
                {3'd4, 6'd13}: decoded = 8'h59; // Y
                {3'd4, 6'd14}: decoded = 8'h4A; // J
                {3'd5, 6'd0}:  decoded = 8'h35; // 5
                {3'd5, 6'd1}:  decoded = 8'h36; // 6
                {3'd5, 6'd3}:  decoded = 8'h37; // 7
                {3'd5, 6'd7}:  decoded = 8'h38; // 8
                {3'd5, 6'd15}: decoded = 8'h39; // 9
                {3'd5, 6'd16}: decoded = 8'h34; // 4
                {3'd5, 6'd24}: decoded = 8'h33; // 3
                {3'd5, 6'd28}: decoded = 8'h32; // 2
                {3'd5, 6'd30}: decoded = 8'h31; // 1
                {3'd5, 6'd31}: decoded = 8'h30; // 0
                default:       decoded = 8'h3F; // ?
            endcase
        end
    end

    logic       push;
    logic [7:0] push_data;
    assign push      = decode_en | space_en;
    assign push_data = decode_en ? decoded : 8'h20;

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push_ok;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop     = read_en && !empty;
    // A pop on the same cycle frees a slot, so a push into a full FIFO is
    // accepted in that case.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    assign ascii_out = empty ? 8'h00 : mem[rd_ptr];

`ifdef MORSE_RX_OVERFLOW_EN
    logic drop;
    logic overflow_q;

    assign drop = push && full && !pop;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_morse_rx.sv
// tb/tb_morse_rx.sv - scoreboard testbench for morse_rx

module tb_morse_rx;

    localparam int P = 100;

    logic       clk;
    logic       arst_n;
    logic       morse_in;
    logic       read_en;
    logic [7:0] ascii_out;
    logic       empty;
    logic       overflow;

    int vectors;
    int miscompares;
    bit mon_en;
    logic [7:0] exp_q[$];

    morse_rx #(.PRESCALER(P), .DEPTH(4)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .morse_in  (morse_in),
        .read_en   (read_en),
        .ascii_out (ascii_out),
        .empty     (empty),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops every character the DUT presents and compares it with
    // the head of the expected queue.
    initial begin
        read_en = 1'b0;
        forever begin
            @(negedge clk);
            read_en = 1'b0;
            if (mon_en && !empty) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_char: got %0h, expected none", ascii_out);
                end else begin
                    check("fifo_char", {24'd0, ascii_out}, {24'd0, exp_q.pop_front()});
                end
                read_en = 1'b1;
            end
        end
    end

    task automatic key(input logic lvl, input int n);
        morse_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends one character ('.' = dot, '-' = dash) with 1-unit intra gaps
    // and a trailing 3-unit letter gap.
    task automatic send_char(input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            key(1'b1, (pat[i] == "-") ? 3 * P : P);
            if (i != pat.len() - 1) key(1'b0, P);
        end
        key(1'b0, 3 * P);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !empty) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        int cnt;
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        morse_in    = 1'b0;
        arst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_empty", empty, 1);
        check("reset_ascii", ascii_out, 8'h00);
        check("reset_overflow", overflow, 0);
        arst_n = 1'b1;
        key(1'b0, 10);

        // Single 'E': check the push latency, then the pop.
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h20);
        key(1'b1, P);
        morse_in = 1'b0;
        cnt = 0;
        while (empty && cnt < 400) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("e_latency_in_window", (cnt >= 2 * P + 2 && cnt <= 2 * P + 4), 1);
        check("e_head", ascii_out, 8'h45);
        mon_en = 1'b1;
        key(1'b0, 4);
        check("e_popped_empty", empty, 1);
        check("e_popped_ascii", ascii_out, 8'h00);
        key(1'b0, 400);
        wait_drain();

        // "CARS" followed by a word gap, then a long idle.
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h52);
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h20);
        send_char("-.-.");
        send_char(".-");
        send_char(".-.");
        send_char("...");
        key(1'b0, 4 * P);
        wait_drain();
        key(1'b0, 1000);
        check("no_second_space", empty, 1);

        // A glitch while idle pushes nothing.
        key(1'b1, 30);
        key(1'b0, 3 * P);
        check("idle_glitch_empty", empty, 1);

        // A glitch between the two dots of 'I' is ignored.
        exp_q.push_back(8'h49);
        exp_q.push_back(8'h20);
        key(1'b1, P);
        key(1'b0, 35);
        key(1'b1, 30);
        key(1'b0, 35);
        key(1'b1, P);
        key(1'b0, 7 * P);
        wait_drain();

        // Seven dots, then an unlisted six-symbol pattern.
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'h3F);
        exp_q.push_back(8'h20);
        send_char(".......");
        send_char(".-.-.-");
        key(1'b0, 4 * P);
        wait_drain();

        // Five 'E's with no reads: the fifth is dropped.
        mon_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back(8'h45);
            send_char(".");
            if (i == 0) check("ovf_first_not_empty", empty, 0);
        end
`ifdef MORSE_RX_OVERFLOW_EN
        check("ovf_flag", overflow, 1);
`else
        check("ovf_flag", overflow, 0);
`endif
        exp_q.push_back(8'h20);
        mon_en = 1'b1;
        key(1'b0, 4 * P);
        wait_drain();

        // Reset mid-dash after one dot of 'A', then 'T'.
        key(1'b1, P);
        key(1'b0, P);
        key(1'b1, 150);
        arst_n = 1'b0;
        key(1'b1, 2);
        check("rst_mid_empty", empty, 1);
        check("rst_mid_ascii", ascii_out, 8'h00);
        check("rst_mid_overflow", overflow, 0);
        morse_in = 1'b0;
        key(1'b0, 3);
        arst_n = 1'b1;
        key(1'b0, 50);
        exp_q.push_back(8'h54);
        exp_q.push_back(8'h20);
        send_char("-");
        key(1'b0, 4 * P);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
